mem_unit: RTL and testbench
===========================

# mem_unit

Parametrised successor to the single-port word memory used for the instruction, data and port memories. It adds configurable data width and depth, and a valid/ready request handshake. It supports single-word and double-word (two-cycle) accesses, registered read data, out-of-range detection, and a sequential clear sweep after reset. It sits between the pipeline memory stage and the storage array, and serves 32-bit operations (PC push/pop, immediates) on a 16-bit word array.

## Interface
- DATA_W, 16, width of one memory word
- DEPTH, 1024, number of words; any value ≥ 2
- ADDR_W, 32, address bus width
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low reset; asserting it (0) immediately forces all registers and outputs to their reset values
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request this cycle; reset value 0
- req_write  input  1  1 = write, 0 = read; sampled on accept
- req_wide  input  1  1 = double-word access, 0 = single word; sampled on accept
- address  input  ADDR_W  word address; sampled on accept
- data_in  input  2*DATA_W  write data; single-word writes use [DATA_W-1:0]
- data_out  output  2*DATA_W  registered read data; reset value 0
- rsp_valid  output  1  one-cycle pulse when an accepted request completes; reset value 0
- addr_err  output  1  qualifies rsp_valid: request was out of range; reset value 0

## Operation
- Accept: a request is accepted on a rising edge where req_valid && req_ready.
- FSM states:
  - INIT: clear sweep. Writes 0 to word clr_cnt each cycle, clr_cnt = 0..DEPTH-1. req_ready=0. Goes to IDLE after word DEPTH-1 is written.
  - IDLE: req_ready=1.
  - WIDE2: second half of a wide access. req_ready=0. Always returns to IDLE.
- Reset state is INIT, with clr_cnt = 0.
- Single word:
  - Write: mem[address] <= data_in[DATA_W-1:0].
  - Read: data_out <= {DATA_W zeros, mem[address]}.
  - Either way, completes in the accept cycle; FSM stays in IDLE.
- Wide access covers two words: the low half is mem[A] and the high half is mem[A+1].
  - A+1 is computed modulo DEPTH, so A = DEPTH-1 wraps to word 0.
  - Accept cycle: write or read of the low half; A is latched; FSM goes to WIDE2.
  - WIDE2: write or read of the high half. Write data is the data_in[2*DATA_W-1:DATA_W] latched at accept.
- Range check: an address ≥ DEPTH is an error, checked at accept.
  - No write occurs and no state transition occurs; a wide request does not enter WIDE2.
  - data_out <= 0, and rsp_valid=1 with addr_err=1 in the next cycle.
- addr_err is 0 on every other response.
- data_out holds its last value between responses. Writes complete with rsp_valid=1 and leave data_out unchanged.
- Reset asserted mid-operation:
  - Any WIDE2 in progress is aborted. A partial wide write leaves the low half written, then the INIT sweep clears it if enabled.
  - Any INIT sweep in progress restarts from word 0 after reset is released.
- Requests with req_valid=1 while req_ready=0 are ignored and not queued. The requester holds them.

## Timing
- Single word: accept on edge N; rsp_valid and data_out valid during cycle N+1; back-to-back accepts every cycle.
- Wide: accept on edge N; WIDE2 on edge N+1; rsp_valid and full data_out during N+2; next accept no earlier than edge N+2.
- Error: rsp_valid and addr_err during N+1; next accept possible on edge N+1.
- INIT: req_ready rises DEPTH cycles after reset is released.
- rsp_valid is never high for two consecutive cycles from one request.

## Configuration
- MEM_INIT_CLEAR_EN defined: INIT state and sweep exist as described; contents are 0 after every reset.
- Not defined:
  - No INIT state; the reset state is IDLE, and req_ready=1 in the first cycle after reset is released.
  - Memory contents are not touched by reset. Simulation starts with X/undefined contents unless loaded externally.

## Test plan
- Reset and sweep (macro on, DEPTH=16): release reset, then read words 0..15 → req_ready rises after 16 cycles; all reads return 0.
- Single-word write/read: write 0xBEEF @5, then read @5 → rsp_valid each cycle; data_out = 0x0000BEEF one cycle after the read accept.
- Wide wrap (DEPTH=16): wide write 0x12345678 @15, then read @15 and @0 → 0x5678 and 0x1234; req_ready low in the cycle after each wide accept.
- Out-of-range: wide write @16 (DEPTH=16), then read all words → rsp_valid with addr_err=1 and data_out=0; no word modified; req_ready stays 1.
- Reset mid-wide: wide write 0xAAAA5555 @3, assert reset during WIDE2 → outputs 0 immediately; after the sweep, word 3 and word 4 read 0.
- Macro off: release reset → req_ready=1 in cycle 1; a write/read pair at @7 round-trips 0x00C3.

Source files
------------

// File: rtl/mem_unit_if.sv
// mem_unit_if: request/response bundle between a memory-stage requester and mem_unit.
interface mem_unit_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 32
);
    logic                req_valid;
    logic                req_ready;
    logic                req_write;
    logic                req_wide;
    logic [ADDR_W-1:0]   address;
    logic [2*DATA_W-1:0] data_in;
    logic [2*DATA_W-1:0] data_out;
    logic                rsp_valid;
    logic                addr_err;

    modport master (
        output req_valid, req_write, req_wide, address, data_in,
        input  req_ready, data_out, rsp_valid, addr_err
    );
    modport slave (
        input  req_valid, req_write, req_wide, address, data_in,
        output req_ready, data_out, rsp_valid, addr_err
    );
endinterface

// File: rtl/mem_unit.sv
// mem_unit: parametrised word memory with valid/ready requests, single/double-word accesses
// and range checking. Define MEM_INIT_CLEAR_EN to add the post-reset clear sweep (INIT state).
module mem_unit #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 32
) (
    input  logic      clk,
    input  logic      reset,
    mem_unit_if.slave bus
);
    localparam int                IDX_W    = $clog2(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_WIDE2 = 2'd2;
`ifdef MEM_INIT_CLEAR_EN
    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_RESET = ST_INIT;
`else
    localparam logic [1:0] ST_RESET = ST_IDLE;
`endif

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [1:0]          state_r;
    logic [1:0]          next_state_s;
    logic                ready_r;
    logic                rsp_valid_r;
    logic                addr_err_r;
    logic [2*DATA_W-1:0] data_out_r;
    logic [IDX_W-1:0]    wide_addr_r;
    logic [IDX_W-1:0]    wide_next_s;
    logic [IDX_W-1:0]    idx_s;
    logic [IDX_W-1:0]    waddr_s;
    logic                wide_write_r;
    logic [DATA_W-1:0]   hi_data_r;
    logic [DATA_W-1:0]   lo_data_r;
    logic [DATA_W-1:0]   wdata_s;
    logic                we_s;
    logic                accept_s;
    logic                range_err_s;
`ifdef MEM_INIT_CLEAR_EN
    logic [IDX_W-1:0]    clr_cnt_r;
`endif

    // ready_r is only ever high in IDLE, so an accept implies the IDLE state.
    assign accept_s    = bus.req_valid && ready_r;
    assign range_err_s = (bus.address >= DEPTH_A);
    assign idx_s       = bus.address[IDX_W-1:0];
    assign wide_next_s = (wide_addr_r == LAST_IDX) ? {IDX_W{1'b0}} : wide_addr_r + IDX_W'(1);

    assign bus.req_ready = ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.addr_err  = addr_err_r;
    assign bus.data_out  = data_out_r;

    // Next-state logic of the INIT/IDLE/WIDE2 controller.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
`ifdef MEM_INIT_CLEAR_EN
            ST_INIT: begin
                if (clr_cnt_r == LAST_IDX) next_state_s = ST_IDLE;
                else                       next_state_s = ST_INIT;
            end
`endif
            ST_IDLE: begin
                if (accept_s && bus.req_wide && !range_err_s) next_state_s = ST_WIDE2;
                else                                          next_state_s = ST_IDLE;
            end
            ST_WIDE2: next_state_s = ST_IDLE;
            default:  next_state_s = ST_RESET;
        endcase
    end

    // Single write port shared by the clear sweep, the accept cycle and WIDE2.
    always_comb begin
        we_s    = 1'b0;
        waddr_s = idx_s;
        wdata_s = bus.data_in[DATA_W-1:0];
        case (state_r)
`ifdef MEM_INIT_CLEAR_EN
            ST_INIT: begin
                we_s    = reset;
                waddr_s = clr_cnt_r;
                wdata_s = {DATA_W{1'b0}};
            end
`endif
            ST_IDLE: begin
                if (accept_s && bus.req_write && !range_err_s) we_s = reset;
                else                                           we_s = 1'b0;
            end
            ST_WIDE2: begin
                if (wide_write_r) begin
                    we_s    = reset;
                    waddr_s = wide_next_s;
                    wdata_s = hi_data_r;
                end else begin
                    we_s = 1'b0;
                end
            end
            default: we_s = 1'b0;
        endcase
    end

    // Storage array; contents are deliberately not touched by reset.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem[waddr_s] <= wdata_s;
        end
    end

`ifdef MEM_INIT_CLEAR_EN
    // Sweep pointer; restarts from word 0 whenever reset is asserted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clr_cnt_r <= {IDX_W{1'b0}};
        end else if (state_r == ST_INIT) begin
            clr_cnt_r <= clr_cnt_r + IDX_W'(1);
        end else begin
            clr_cnt_r <= clr_cnt_r;
        end
    end
`endif

    // Controller state, handshake/response outputs and wide-access latches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_RESET;
            ready_r      <= 1'b0;
            rsp_valid_r  <= 1'b0;
            addr_err_r   <= 1'b0;
            data_out_r   <= {2*DATA_W{1'b0}};
            wide_addr_r  <= {IDX_W{1'b0}};
            wide_write_r <= 1'b0;
            hi_data_r    <= {DATA_W{1'b0}};
            lo_data_r    <= {DATA_W{1'b0}};
        end else begin
            state_r     <= next_state_s;
            ready_r     <= (next_state_s == ST_IDLE);
            rsp_valid_r <= 1'b0;
            addr_err_r  <= 1'b0;
            if (state_r == ST_WIDE2) begin
                rsp_valid_r <= 1'b1;
                if (!wide_write_r) begin
                    data_out_r <= {mem[wide_next_s], lo_data_r};
                end
            end else if (accept_s) begin
                if (range_err_s) begin
                    rsp_valid_r <= 1'b1;
                    addr_err_r  <= 1'b1;
                    data_out_r  <= {2*DATA_W{1'b0}};
                end else if (bus.req_wide) begin
                    // Low half is handled now; data_out only changes once both halves exist.
                    wide_addr_r  <= idx_s;
                    wide_write_r <= bus.req_write;
                    hi_data_r    <= bus.data_in[2*DATA_W-1:DATA_W];
                    lo_data_r    <= mem[idx_s];
                end else begin
                    rsp_valid_r <= 1'b1;
                    if (!bus.req_write) begin
                        data_out_r <= {{DATA_W{1'b0}}, mem[idx_s]};
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_unit.sv
// tb_mem_unit: directed + randomized check of mem_unit (DEPTH=16) against a per-edge
// behavioural model; expectations adapt to whether MEM_INIT_CLEAR_EN is defined.
`timescale 1ns/1ps
module tb_mem_unit;
    localparam int D    = 16;
    localparam int NCYC = 2048;
`ifdef MEM_INIT_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_unit_if #(.DATA_W(16), .ADDR_W(32)) bus();
    mem_unit #(.DATA_W(16), .DEPTH(D), .ADDR_W(32)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc;

    // Expected outputs per cycle, indexed by clock edges since reset release.
    bit          e_set   [NCYC];
    bit          e_ready [NCYC];
    bit          e_rsp   [NCYC];
    bit          e_err   [NCYC];
    bit          e_kn    [NCYC];
    logic [31:0] e_do    [NCYC];

    // Model state: word array with known flags, pending wide half, current data_out.
    logic [15:0] m_mem [D];
    bit          m_kn  [D];
    int          next_ok;
    bit          pend;
    bit          pend_wr;
    int          pend_a;
    int          pend_edge;
    logic [15:0] pend_hi;
    logic [15:0] pend_lo;
    bit          pend_lo_kn;
    logic [31:0] cur_do;
    bit          cur_kn;
    bit          m_acc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        next_ok = CLR ? D + 1 : 2;
        pend    = 1'b0;
        cur_do  = 32'h0;
        cur_kn  = 1'b1;
        m_acc   = 1'b0;
        for (int i = 0; i < NCYC; i++) e_set[i] = 1'b0;
        for (int i = 0; i < D; i++) begin
            if (CLR) begin
                m_mem[i] = 16'h0;
                m_kn[i]  = 1'b1;
            end
        end
    endtask

    // One rising edge k with the given request inputs.
    task automatic model_edge(input int k, input bit v, input bit wr, input bit wd,
                              input logic [31:0] a, input logic [31:0] din);
        bit rsp = 1'b0;
        bit err = 1'b0;
        int ai;
        m_acc = 1'b0;
        if (pend && k == pend_edge) begin
            pend = 1'b0;
            rsp  = 1'b1;
            ai   = (pend_a + 1) % D;
            if (pend_wr) begin
                m_mem[ai] = pend_hi;
                m_kn[ai]  = 1'b1;
            end else begin
                cur_do = {m_mem[ai], pend_lo};
                cur_kn = m_kn[ai] && pend_lo_kn;
            end
        end else if (v && k >= next_ok) begin
            m_acc = 1'b1;
            if (a >= 32'(D)) begin
                rsp = 1'b1; err = 1'b1;
                cur_do = 32'h0; cur_kn = 1'b1;
                next_ok = k + 1;
            end else begin
                ai = int'(a);
                if (wd) begin
                    pend = 1'b1; pend_edge = k + 1; pend_a = ai; pend_wr = wr;
                    pend_hi = din[31:16]; pend_lo = m_mem[ai]; pend_lo_kn = m_kn[ai];
                    next_ok = k + 2;
                end else begin
                    rsp = 1'b1;
                    next_ok = k + 1;
                    if (!wr) begin
                        cur_do = {16'h0, m_mem[ai]};
                        cur_kn = m_kn[ai];
                    end
                end
                if (wr) begin
                    m_mem[ai] = din[15:0];
                    m_kn[ai]  = 1'b1;
                end
            end
        end
        if (k < NCYC) begin
            e_set[k]   = 1'b1;
            e_ready[k] = (k + 1 >= next_ok);
            e_rsp[k]   = rsp;
            e_err[k]   = err;
            e_do[k]    = cur_do;
            e_kn[k]    = cur_kn;
        end
    endtask

    // Called at a falling edge: drive inputs for the next rising edge, then advance.
    task automatic step(input bit v, input bit wr, input bit wd,
                        input logic [31:0] a, input logic [31:0] din);
        bus.req_valid = v;
        bus.req_write = wr;
        bus.req_wide  = wd;
        bus.address   = a;
        bus.data_in   = din;
        model_edge(cyc + 1, v, wr, wd, a, din);
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Hold a request until accepted; returns in the cycle after the accepting edge.
    task automatic req(input bit wr, input bit wd, input logic [31:0] a, input logic [31:0] din);
        int n = 0;
        do begin
            step(1'b1, wr, wd, a, din);
            n++;
        end while (!m_acc && n < 100);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_ready();
        int lat = 0;
        while (!bus.req_ready && lat < 200) begin
            step(1'b1, 1'b0, 1'b0, 32'd5, 32'h0);
            lat++;
        end
        chk("ready_latency", 32'(lat), CLR ? 32'(D) : 32'd1);
    endtask

    // Every-cycle comparison of the DUT against the model tables.
    always @(posedge clk) begin
        #1;
        if (rst_n && cyc > 0 && cyc < NCYC && e_set[cyc]) begin
            chk("req_ready", 32'(bus.req_ready), 32'(e_ready[cyc]));
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_rsp[cyc]));
            chk("addr_err",  32'(bus.addr_err),  32'(e_err[cyc]));
            if (e_kn[cyc]) chk("data_out", bus.data_out, e_do[cyc]);
        end
    end

    initial begin
        for (int i = 0; i < D; i++) m_kn[i] = 1'b0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_wide = 1'b0;
        bus.address = 32'h0; bus.data_in = 32'h0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp",   32'(bus.rsp_valid), 32'd0);
        chk("rst_err",   32'(bus.addr_err),  32'd0);
        chk("rst_data",  bus.data_out,       32'h0);

        rst_n = 1'b1;
        wait_ready();
        for (int a = 0; a < D; a++) req(1'b0, 1'b0, 32'(a), 32'h0);

        req(1'b1, 1'b0, 32'd5, 32'h1111BEEF);
        chk("wr5_rsp", 32'(bus.rsp_valid), 32'd1);
        req(1'b0, 1'b0, 32'd5, 32'h0);
        chk("rd5_data", bus.data_out, 32'h0000BEEF);
        chk("rd5_model", cur_do, 32'h0000BEEF);

        req(1'b1, 1'b1, 32'd15, 32'h12345678);
        chk("wide_ready_low", 32'(bus.req_ready), 32'd0);
        chk("wide_no_early_rsp", 32'(bus.rsp_valid), 32'd0);
        idle();
        chk("wide_rsp", 32'(bus.rsp_valid), 32'd1);
        req(1'b0, 1'b0, 32'd15, 32'h0);
        chk("rd15_data", bus.data_out, 32'h00005678);
        req(1'b0, 1'b0, 32'd0, 32'h0);
        chk("rd0_wrap", bus.data_out, 32'h00001234);
        req(1'b0, 1'b1, 32'd15, 32'h0);
        chk("wide_rd_ready_low", 32'(bus.req_ready), 32'd0);
        idle();
        chk("wide_rd_data", bus.data_out, 32'h12345678);
        chk("wide_rd_model", cur_do, 32'h12345678);

        req(1'b1, 1'b1, 32'd16, 32'hDEADBEEF);
        chk("oor_rsp",   32'(bus.rsp_valid), 32'd1);
        chk("oor_err",   32'(bus.addr_err),  32'd1);
        chk("oor_data",  bus.data_out,       32'h0);
        chk("oor_ready", 32'(bus.req_ready), 32'd1);
        req(1'b1, 1'b0, 32'h0001_0003, 32'h0000FFFF);
        chk("oor_hi_err", 32'(bus.addr_err), 32'd1);
        for (int a = 0; a < D; a++) req(1'b0, 1'b0, 32'(a), 32'h0);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] ra;
            if ($urandom_range(9, 0) == 0) ra = 32'h0001_0000 | 32'($urandom_range(15, 0));
            else                           ra = 32'($urandom_range(D + 1, 0));
            step($urandom_range(99, 0) < 75, 1'($urandom_range(1, 0)),
                 1'($urandom_range(1, 0)), ra, $urandom);
        end
        repeat (3) idle();

        req(1'b1, 1'b1, 32'd3, 32'hAAAA5555);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(bus.req_ready), 32'd0);
        chk("midrst_rsp",   32'(bus.rsp_valid), 32'd0);
        chk("midrst_err",   32'(bus.addr_err),  32'd0);
        chk("midrst_data",  bus.data_out,       32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_ready();
        req(1'b0, 1'b0, 32'd3, 32'h0);
        chk("midrst_w3", bus.data_out, CLR ? 32'h0 : 32'h00005555);
        req(1'b0, 1'b0, 32'd4, 32'h0);

        req(1'b1, 1'b0, 32'd7, 32'h000000C3);
        req(1'b0, 1'b0, 32'd7, 32'h0);
        chk("rt7_data", bus.data_out, 32'h000000C3);
        repeat (3) idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
